// File: rtl/pc_unit.sv
// Program counter with branch/jump/register/exception sources, EPC capture
// and a circular return-address stack for call/return prediction.
module pc_unit #(
  parameter int                WIDTH        = 32,
  parameter int                DEPTH        = 4,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0]  EXC_VECTOR   = 'hFC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_wr,
  input  logic              stall,
  input  logic [2:0]        pc_src,
  input  logic [15:0]       imm,
  input  logic [25:0]       jtarget,
  input  logic [WIDTH-1:0]  reg_in,
  input  logic              push,
  input  logic              exc,
  output logic [WIDTH-1:0]  pc_out,
  output logic [WIDTH-1:0]  epc_out,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_overflow,
  output logic              ras_underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [WIDTH-1:0] FOUR     = WIDTH'(4);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic             update;
  logic             is_empty;
  logic             is_full;
  logic [PW-1:0]    ptr_inc;
  logic [WIDTH-1:0] pc4;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] branch_tgt;
  logic [WIDTH-1:0] jump_tgt;
  logic [27:0]      jt_word;

  assign update     = (pc_wr && !stall) || exc;
  assign is_empty   = (cnt_q == '0);
  assign is_full    = (cnt_q == FULL_CNT);
  assign ptr_inc    = ptr_q + PW'(1);
  assign pc4        = pc_q + FOUR;
  assign imm_ext    = WIDTH'($signed(imm));
  assign branch_tgt = pc4 + (imm_ext << 2);
  assign jt_word    = {jtarget, 2'b00};

  // Only the low min(WIDTH,28) bits of the jump come from the instruction.
  if (WIDTH > 28) begin : g_jump_wide
    assign jump_tgt = {pc4[WIDTH-1:28], jt_word};
  end else begin : g_jump_narrow
    assign jump_tgt = jt_word[WIDTH-1:0];
  end

  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = 1'b0;
    mem_d = mem_q;
    if (exc) begin
      pc_d  = EXC_VECTOR;
      epc_d = pc_q;
    end else if (update) begin
      case (pc_src)
        3'd1:    pc_d = branch_tgt;
        3'd2:    pc_d = jump_tgt;
        3'd3:    pc_d = reg_in;
        3'd4:    pc_d = EXC_VECTOR;
        3'd5:    pc_d = epc_q;
        3'd6: begin
          if (!is_empty) begin
            pc_d = mem_q[ptr_q];
          end else begin
            pc_d  = pc4;
            unf_d = 1'b1;
          end
        end
        default: pc_d = pc4;
      endcase
      // A pop+push on a non-empty stack swaps the top in place.
      if (pc_src == 3'd6 && !is_empty) begin
        if (push) begin
          mem_d[ptr_q] = pc4;
        end else begin
          ptr_d = ptr_q - PW'(1);
          cnt_d = cnt_q - CW'(1);
        end
      end else if (push) begin
        ptr_d          = ptr_inc;
        mem_d[ptr_inc] = pc4;
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_VECTOR;
      epc_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign pc_out        = pc_q;
  assign epc_out       = epc_q;
  assign ras_empty     = is_empty;
  assign ras_full      = is_full;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule
